rv_machine_csr_file: RTL and testbench
======================================

// Module: rv_machine_csr_file
// PURPOSE
//  RV32 machine-mode CSR file beside the control sequencer (instruction decode is a separate block).
//  Serves Zicsr read/write/set/clear from the shared data bus, captures trap state (mepc/mcause/mtval/mstatus),
//  restores it on mret. Trap vector is fixed at 0x4 by the controller; this block only records state.
// PARAMETERS
//  MISA_VAL  32'h4000_0100  misa read value (RV32I)
//  HART_ID   32'd0          mhartid read value
// PORTS
//  clk                     in   1   rising-edge clock
//  rst                     in   1   synchronous, active-high reset
//  csr_addr                in   12  CSR address (controller forces 12'h341 during mret)
//  addr                    in   32  address bus; faulting address for mtval
//  bus                     in   32  data bus; CSR write operand (rs1 value or zimm)
//  pc                      in   32  PC of current instruction
//  csr_out                 out  32  combinational read data of csr_addr
//  read                    in   1   CSR read step active
//  write                   in   1   CSR write strobe
//  write_type              in   2   01 write, 10 set bits, 11 clear bits, 00 no-op
//  trap                    in   1   trap taken this cycle
//  trap_cause              in   5   exception/interrupt code
//  take_external_interupt  in   1   trap is machine external interrupt
//  ret                     in   1   current instruction is mret
//  invalid                 out  1   csr_addr unimplemented, or write to read-only (csr_addr[11:10]==2'b11)
// BEHAVIOUR
//  - Implemented: mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343,
//    mip 344, mcycle/mcycleh B00/B80, minstret/minstreth B02/B82, cycle/cycleh C00/C80, mvendorid F11,
//    marchid F12, mimpid F13, mhartid F14. csr_out=0 and invalid=1 for any other address.
//  - Reset: mstatus MIE/MPIE=0, mie, mscratch, mepc, mcause, mtval, counters=0.
//  - Read-only values: misa=MISA_VAL, mtvec=0x4, mip=0, mvendorid/marchid/mimpid=0, mhartid=HART_ID,
//    mstatus.MPP reads 2'b11. Writes to misa/mtvec/mip ignored (no invalid). minstret reads 0 (no retire input).
//  - csr_out, invalid combinational; invalid independent of read/write except read-only check.
//  - Write at posedge when write && !trap: new = 01: bus; 10: old|bus; 11: old&~bus; 00: unchanged.
//    mstatus writable bits MIE[3], MPIE[7] only; mepc[1:0] forced 0; mie only bit 11 (MEIE).
//  - mcycle 64-bit, +1 every cycle; a write to either half loads that half that cycle, no increment.
//  - Trap at posedge (priority over write and ret): mepc<=pc; mcause<={take_external_interupt,26'b0,trap_cause};
//    mtval<=addr for causes 1,4,5,6,7 (exceptions only), else 0; MPIE<=MIE; MIE<=0.
//  - mret at posedge when ret && read && !trap: MIE<=MPIE, MPIE<=1. Gating on read prevents a second
//    update while ret stays high into the next fetch. mepc is driven on csr_out in the same cycle.
//  - No interrupt gating here; acceptance is the controller's decision.
//  - rst dominates all events.
// STRUCTURE
//  - Shared package riscv_pkg: CSR address localparams, mcause codes (1,2,3,4,5,6,7,11), write_type enum,
//    mstatus bit positions.
//  - Sub-module rv_csr_counter64: 64-bit counter with per-half load.
// TESTING
//  - Reset; read 301 -> csr_out=0x40000100, invalid=0; read 0x7C0 -> invalid=1, csr_out=0.
//  - write 340, type 01, bus=0xDEADBEEF -> read 340 = 0xDEADBEEF; type 10 bus=0x10 -> 0xDEADBEFF;
//    type 11 bus=0xFF -> 0xDEADBE00.
//  - trap, cause 5, pc=0x100, addr=0x90000, MIE=1 -> mepc=0x100, mcause=5, mtval=0x90000, MIE=0, MPIE=1.
//  - trap with take_external_interupt=1, cause 11 -> mcause=0x8000000B, mtval=0.
//  - ret && read, csr_addr=341 after prior trap -> csr_out=0x100; next cycle MIE=1; ret held 3 more cycles -> no change.
//  - write to F14 -> invalid=1; trap && write same cycle -> write dropped; mcycle advances by 1 per cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 machine-mode CSR definitions: addresses, trap cause codes,
// Zicsr write operations and mstatus field positions.
package riscv_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [4:0] CAUSE_INSN_FAULT      = 5'd1;
    localparam logic [4:0] CAUSE_ILLEGAL_INSN    = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT      = 5'd3;
    localparam logic [4:0] CAUSE_LOAD_MISALIGNED = 5'd4;
    localparam logic [4:0] CAUSE_LOAD_FAULT      = 5'd5;
    localparam logic [4:0] CAUSE_STORE_MISALIGN  = 5'd6;
    localparam logic [4:0] CAUSE_STORE_FAULT     = 5'd7;
    localparam logic [4:0] CAUSE_ECALL_M         = 5'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;
    localparam int MIE_MEIE     = 11;

    typedef enum logic [1:0] {
        WT_NOP   = 2'b00,
        WT_WRITE = 2'b01,
        WT_SET   = 2'b10,
        WT_CLEAR = 2'b11
    } write_type_t;

    // Causes whose faulting address is meaningful in mtval.
    function automatic logic cause_has_tval(input logic [4:0] cause);
        return cause inside {CAUSE_INSN_FAULT, CAUSE_LOAD_MISALIGNED, CAUSE_LOAD_FAULT,
                             CAUSE_STORE_MISALIGN, CAUSE_STORE_FAULT};
    endfunction

    function automatic logic [31:0] csr_update(input logic [31:0] old, input logic [31:0] operand,
                                               input write_type_t wt);
        case (wt)
            WT_WRITE: return operand;
            WT_SET:   return old | operand;
            WT_CLEAR: return old & ~operand;
            default:  return old;
        endcase
    endfunction

endpackage

// File: rtl/rv_csr_counter64.sv
// Free-running 64-bit counter; loading either half suppresses that cycle's increment.
module rv_csr_counter64
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_val,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 64'd0;
        end else if (load_lo || load_hi) begin
            if (load_lo) count[31:0]  <= load_val;
            if (load_hi) count[63:32] <= load_val;
        end else begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/rv_machine_csr_file.sv
// RV32 machine-mode CSR file: Zicsr access, trap state capture and mret restore.
module rv_machine_csr_file
    import riscv_pkg::*;
#(
    parameter logic [31:0] MISA_VAL = 32'h4000_0100,
    parameter logic [31:0] HART_ID  = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [31:0] addr,
    input  logic [31:0] bus,
    input  logic [31:0] pc,
    output logic [31:0] csr_out,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  write_type,
    input  logic        trap,
    input  logic [4:0]  trap_cause,
    input  logic        take_external_interupt,
    input  logic        ret,
    output logic        invalid
);

    logic        st_mie, st_mpie, meie;
    logic [31:0] mscratch, mepc, mcause, mtval;
    logic [63:0] mcycle;
    logic [31:0] mstatus_rd, new_val;
    logic        implemented, wr_en;
    write_type_t wt;

    assign wt    = write_type_t'(write_type);
    assign wr_en = write && !trap && (wt != WT_NOP);

    always_comb begin
        mstatus_rd                                = 32'd0;
        mstatus_rd[MSTATUS_MIE]                   = st_mie;
        mstatus_rd[MSTATUS_MPIE]                  = st_mpie;
        mstatus_rd[MSTATUS_MPP+1:MSTATUS_MPP]     = 2'b11;
    end

    always_comb begin
        csr_out     = 32'd0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:                csr_out = mstatus_rd;
            CSR_MISA:                   csr_out = MISA_VAL;
            CSR_MIE:                    csr_out = {20'd0, meie, 11'd0};
            CSR_MTVEC:                  csr_out = 32'h4;
            CSR_MSCRATCH:               csr_out = mscratch;
            CSR_MEPC:                   csr_out = mepc;
            CSR_MCAUSE:                 csr_out = mcause;
            CSR_MTVAL:                  csr_out = mtval;
            CSR_MCYCLE, CSR_CYCLE:      csr_out = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:    csr_out = mcycle[63:32];
            CSR_MHARTID:                csr_out = HART_ID;
            CSR_MIP, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_out = 32'd0;
            default:                    implemented = 1'b0;
        endcase
    end

    // The read-only check only fires on an actual write strobe.
    assign invalid = !implemented || (write && (csr_addr[11:10] == 2'b11));
    assign new_val = csr_update(csr_out, bus, wt);

    rv_csr_counter64 u_mcycle (
        .clk      (clk),
        .rst      (rst),
        .load_lo  (wr_en && (csr_addr == CSR_MCYCLE)),
        .load_hi  (wr_en && (csr_addr == CSR_MCYCLEH)),
        .load_val (new_val),
        .count    (mcycle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            meie     <= 1'b0;
            mscratch <= 32'd0;
            mepc     <= 32'd0;
            mcause   <= 32'd0;
            mtval    <= 32'd0;
        end else if (trap) begin
            mepc    <= pc;
            mcause  <= {take_external_interupt, 26'd0, trap_cause};
            mtval   <= (!take_external_interupt && cause_has_tval(trap_cause)) ? addr : 32'd0;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else begin
            if (wr_en) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        st_mie  <= new_val[MSTATUS_MIE];
                        st_mpie <= new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE:      meie     <= new_val[MIE_MEIE];
                    CSR_MSCRATCH: mscratch <= new_val;
                    CSR_MEPC:     mepc     <= {new_val[31:2], 2'b00};
                    CSR_MCAUSE:   mcause   <= new_val;
                    CSR_MTVAL:    mtval    <= new_val;
                    default: ;
                endcase
            end
            // read qualifies mret so a ret held into the next fetch restores only once
            if (ret && read) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_machine_csr_file.sv
// Directed self-checking bench for rv_machine_csr_file.
module tb_rv_machine_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [31:0] addr, bus, pc, csr_out;
    logic        read, write, trap, take_external_interupt, ret, invalid;
    logic [1:0]  write_type;
    logic [4:0]  trap_cause;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_machine_csr_file dut (
        .clk                    (clk),
        .rst                    (rst),
        .csr_addr               (csr_addr),
        .addr                   (addr),
        .bus                    (bus),
        .pc                     (pc),
        .csr_out                (csr_out),
        .read                   (read),
        .write                  (write),
        .write_type             (write_type),
        .trap                   (trap),
        .trap_cause             (trap_cause),
        .take_external_interupt (take_external_interupt),
        .ret                    (ret),
        .invalid                (invalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_out, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] wt, input logic [31:0] d);
        csr_addr   = a;
        write      = 1'b1;
        write_type = wt;
        bus        = d;
        tick();
        write      = 1'b0;
        write_type = 2'b00;
    endtask

    task automatic do_trap(input logic ext, input logic [4:0] cause,
                           input logic [31:0] p, input logic [31:0] a);
        trap = 1'b1; take_external_interupt = ext; trap_cause = cause; pc = p; addr = a;
        tick();
        trap = 1'b0; take_external_interupt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; csr_addr = 12'h0; addr = 0; bus = 0; pc = 0;
        read = 0; write = 0; write_type = 2'b00; trap = 0; trap_cause = 0;
        take_external_interupt = 0; ret = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        rd("rst_mcycle", 12'hB00, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        chk("rst_mstatus_inv", {31'd0, invalid}, 32'd0);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mscratch", 12'h340, 32'h0);
        tick();
        rd("mcycle_step", 12'hB00, 32'h1);
        tick();

        rd("misa", 12'h301, 32'h4000_0100);
        chk("misa_inv", {31'd0, invalid}, 32'd0);
        rd("unimpl_out", 12'h7C0, 32'h0);
        chk("unimpl_inv", {31'd0, invalid}, 32'd1);
        rd("mtvec", 12'h305, 32'h4);

        wr(12'h340, 2'b01, 32'hDEAD_BEEF);
        rd("mscratch_wr", 12'h340, 32'hDEAD_BEEF);
        wr(12'h340, 2'b10, 32'h10);
        rd("mscratch_set", 12'h340, 32'hDEAD_BEFF);
        wr(12'h340, 2'b11, 32'hFF);
        rd("mscratch_clr", 12'h340, 32'hDEAD_BE00);
        wr(12'h340, 2'b00, 32'h0);
        rd("mscratch_nop", 12'h340, 32'hDEAD_BE00);

        wr(12'hB00, 2'b01, 32'h100);
        rd("mcycle_load", 12'hB00, 32'h100);
        rd("cycle_alias", 12'hC00, 32'h100);
        tick();
        rd("mcycle_inc", 12'hB00, 32'h101);
        wr(12'hB80, 2'b01, 32'h7);
        rd("mcycleh_load", 12'hB80, 32'h7);
        rd("cycleh_alias", 12'hC80, 32'h7);
        rd("mcycle_hold", 12'hB00, 32'h101);

        wr(12'h300, 2'b01, 32'h8);
        rd("mstatus_mie", 12'h300, 32'h0000_1808);
        wr(12'h300, 2'b01, 32'hFFFF_FFFF);
        rd("mstatus_mask", 12'h300, 32'h0000_1888);
        wr(12'h300, 2'b11, 32'h80);
        rd("mstatus_clr", 12'h300, 32'h0000_1808);

        do_trap(1'b1, 5'd11, 32'h200, 32'h1234);
        rd("ext_mcause", 12'h342, 32'h8000_000B);
        rd("ext_mtval", 12'h343, 32'h0);
        rd("ext_mepc", 12'h341, 32'h200);
        rd("ext_mstatus", 12'h300, 32'h0000_1880);

        wr(12'h300, 2'b10, 32'h8);
        rd("mstatus_set", 12'h300, 32'h0000_1888);
        do_trap(1'b0, 5'd5, 32'h100, 32'h9_0000);
        rd("trap_mepc", 12'h341, 32'h100);
        rd("trap_mcause", 12'h342, 32'h5);
        rd("trap_mtval", 12'h343, 32'h9_0000);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);

        read = 1'b1; ret = 1'b1;
        rd("mret_mepc", 12'h341, 32'h100);
        tick();
        read = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h0000_1888);
        wr(12'h300, 2'b11, 32'h80);
        rd("ret_held_0", 12'h300, 32'h0000_1808);
        tick();
        rd("ret_held_1", 12'h300, 32'h0000_1808);
        tick();
        rd("ret_held_2", 12'h300, 32'h0000_1808);
        ret = 1'b0;

        wr(12'h341, 2'b01, 32'h103);
        rd("mepc_align", 12'h341, 32'h100);
        wr(12'h304, 2'b01, 32'hFFFF_FFFF);
        rd("mie_meie", 12'h304, 32'h800);

        csr_addr = 12'hF14; write = 1'b1; write_type = 2'b01; bus = 32'h55;
        #1 chk("ro_write_inv", {31'd0, invalid}, 32'd1);
        csr_addr = 12'h301;
        #1 chk("misa_write_inv", {31'd0, invalid}, 32'd0);
        write = 1'b0; write_type = 2'b00;
        rd("mhartid", 12'hF14, 32'h0);
        chk("mhartid_rd_inv", {31'd0, invalid}, 32'd0);
        tick();

        csr_addr = 12'h340; write = 1'b1; write_type = 2'b01; bus = 32'h1234_5678;
        do_trap(1'b0, 5'd2, 32'h300, 32'h55);
        write = 1'b0; write_type = 2'b00;
        rd("trapwr_mscratch", 12'h340, 32'hDEAD_BE00);
        rd("trapwr_mtval", 12'h343, 32'h0);
        rd("trapwr_mepc", 12'h341, 32'h300);
        rd("trapwr_mcause", 12'h342, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
